// File: rtl/ef_adc_sar_pkg.sv
// rtl/ef_adc_sar_pkg.sv - shared types and constants for the SAR ADC controller
package ef_adc_sar_pkg;

    localparam int ADC_NBITS = 10;
    localparam int ADC_NCH   = 8;
    localparam int ADC_CHW   = $clog2(ADC_NCH);
    localparam int ADC_IDXW  = $clog2(ADC_NBITS);

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        HOLD,
        TRIAL,
        LOAD,
        COMPARE,
        DONE
    } sar_state_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ef_adc_sar_ctrl_if.sv
// rtl/ef_adc_sar_ctrl_if.sv - host handshake and analog core signals of the SAR controller
// EF_ADC_SAR_CONT_EN adds the cont (continuous conversion) request.
interface ef_adc_sar_ctrl_if;
    import ef_adc_sar_pkg::*;

    logic                 start;
    logic [ADC_CHW-1:0]   chan;
    logic                 busy;
    logic                 done;
    logic [ADC_NBITS-1:0] result;
`ifdef EF_ADC_SAR_CONT_EN
    logic                 cont;
`endif
    logic                 adc_en;
    logic                 adc_hold;
    logic                 adc_rst;
    logic [ADC_CHW-1:0]   adc_b;
    logic [ADC_NBITS-1:0] adc_data;
    logic                 adc_cmp;

    modport master (
`ifdef EF_ADC_SAR_CONT_EN
        input  cont,
`endif
        input  start, chan, adc_cmp,
        output busy, done, result, adc_en, adc_hold, adc_rst, adc_b, adc_data
    );

    modport slave (
`ifdef EF_ADC_SAR_CONT_EN
        output cont,
`endif
        output start, chan, adc_cmp,
        input  busy, done, result, adc_en, adc_hold, adc_rst, adc_b, adc_data
    );

endinterface

// File: rtl/ef_adc_sar_timer.sv
// rtl/ef_adc_sar_timer.sv - loadable down-counter with zero flag for the sample and settle waits
module ef_adc_sar_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ef_adc_sar_ctrl.sv
// rtl/ef_adc_sar_ctrl.sv - successive-approximation controller for the 10-bit 8-channel ADC core
// EF_ADC_SAR_CONT_EN enables back-to-back conversions via cont.
module ef_adc_sar_ctrl
    import ef_adc_sar_pkg::*;
#(
    parameter int SAMPLE_CYCLES = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input logic              clk,
    input logic              rst,
    ef_adc_sar_ctrl_if.master sar_if
);

    localparam int CNT_W = $clog2(max2(SAMPLE_CYCLES, SETTLE_CYCLES) + 1);
    localparam logic [CNT_W-1:0] SAMPLE_LD = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);

    sar_state_e           state_q, state_d;
    logic [ADC_NBITS-1:0] code_q, code_d;
    logic [ADC_IDXW-1:0]  idx_q, idx_d;
    logic [ADC_NBITS-1:0] result_q, result_d;
    logic [ADC_NBITS-1:0] data_q, data_d;
    logic [ADC_CHW-1:0]   b_q, b_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 en_q, en_d;
    logic                 hold_q, hold_d;
    logic                 arst_q, arst_d;

    logic                 tmr_load;
    logic [CNT_W-1:0]     tmr_val;
    logic                 tmr_zero;

    ef_adc_sar_timer #(.W(CNT_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = SAMPLE_LD;
        case (state_q)
            IDLE: begin
                if (sar_if.start) begin
                    state_d  = SAMPLE;
                    tmr_load = 1'b1;
                end
            end
            SAMPLE:  if (tmr_zero) state_d = HOLD;
            HOLD:    state_d = TRIAL;
            TRIAL:   state_d = LOAD;
            LOAD: begin
                state_d  = COMPARE;
                tmr_load = 1'b1;
                tmr_val  = SETTLE_LD;
            end
            COMPARE: if (tmr_zero) state_d = (idx_q == '0) ? DONE : TRIAL;
            DONE: begin
`ifdef EF_ADC_SAR_CONT_EN
                if (sar_if.cont) begin
                    state_d  = SAMPLE;
                    tmr_load = 1'b1;
                end else begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every pin comes straight off a flop.
    always_comb begin
        code_d   = code_q;
        idx_d    = idx_q;
        b_d      = b_q;
        data_d   = data_q;
        result_d = result_q;
        if (state_q == IDLE && sar_if.start) begin
            b_d = sar_if.chan;
        end
        if (state_q == HOLD) begin
            code_d = '0;
            idx_d  = ADC_IDXW'(ADC_NBITS - 1);
        end
        if (state_q == COMPARE && tmr_zero) begin
            code_d[idx_q] = sar_if.adc_cmp;
            if (idx_q != '0) idx_d = idx_q - ADC_IDXW'(1);
        end
        if (state_d == TRIAL) begin
            data_d = code_d | (ADC_NBITS'(1) << idx_d);
        end
        if (state_d == DONE) begin
            result_d = code_d;
        end
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        en_d   = state_d inside {SAMPLE, HOLD, TRIAL, LOAD, COMPARE};
        hold_d = state_d inside {HOLD, TRIAL, LOAD, COMPARE};
        arst_d = (state_d != LOAD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_q   <= '0;
            idx_q    <= '0;
            b_q      <= '0;
            data_q   <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            en_q     <= 1'b0;
            hold_q   <= 1'b0;
            arst_q   <= 1'b1;
        end else begin
            code_q   <= code_d;
            idx_q    <= idx_d;
            b_q      <= b_d;
            data_q   <= data_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            en_q     <= en_d;
            hold_q   <= hold_d;
            arst_q   <= arst_d;
        end
    end

    assign sar_if.busy     = busy_q;
    assign sar_if.done     = done_q;
    assign sar_if.result   = result_q;
    assign sar_if.adc_en   = en_q;
    assign sar_if.adc_hold = hold_q;
    assign sar_if.adc_rst  = arst_q;
    assign sar_if.adc_b    = b_q;
    assign sar_if.adc_data = data_q;

endmodule
